// File: rtl/set_bit_serializer.sv
// set_bit_serializer: accepts a word and emits the index of each set bit,
// lowest first, one beat per handshake. An all-zero word yields a single
// empty beat. Optional macro SET_BIT_SER_COUNT_EN adds out_count, the
// 1-based ordinal of the current beat within its word.
module set_bit_serializer #(
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_W-1:0]      out_index,
   output logic                  out_last,
   output logic                  out_empty
`ifdef SET_BIT_SER_COUNT_EN
   ,
   output logic [IDX_W:0]        out_count
`endif
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] residual, residual_nxt;
   logic [DATA_WIDTH-1:0] residual_dropped;
   logic [IDX_W-1:0]      tz;
   logic                  multi;
   logic                  load;

   // Residual with its lowest set bit cleared; non-zero means more beats follow
   assign residual_dropped = residual & (residual - DATA_WIDTH'(1));
   assign multi            = |residual_dropped;

   // Trailing-zero count of the residual word (scan from MSB so lowest wins)
   always_comb begin
      tz = '0;
      for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
         if (residual[i]) tz = IDX_W'(i);
      end
   end

   // State and residual registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         residual <= '0;
      end else begin
         state    <= state_nxt;
         residual <= residual_nxt;
      end
   end

   // Next-state, residual update and handshake outputs
   always_comb begin
      state_nxt    = state;
      residual_nxt = residual;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_index    = '0;
      out_last     = 1'b0;
      out_empty    = 1'b0;
      load         = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               residual_nxt = in_data;
               state_nxt    = EMIT;
               load         = 1'b1;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_index = tz;
            out_empty = (residual == '0);
            out_last  = !multi;
            if (out_ready) begin
               if (multi) begin
                  residual_nxt = residual_dropped;
               end else begin
                  // Last beat retiring: accept the next word with no bubble
                  in_ready = 1'b1;
                  if (in_valid) begin
                     residual_nxt = in_data;
                     load         = 1'b1;
                  end else begin
                     residual_nxt = '0;
                     state_nxt    = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt    = IDLE;
            residual_nxt = '0;
         end
      endcase
   end

`ifdef SET_BIT_SER_COUNT_EN
   logic [IDX_W:0] count, count_nxt;

   // Beat ordinal: 1 on load of a non-zero word, 0 for an empty word
   always_comb begin
      count_nxt = count;
      if (load)
         count_nxt = (in_data != '0) ? (IDX_W+1)'(1) : '0;
      else if (out_valid && out_ready && multi)
         count_nxt = count + (IDX_W+1)'(1);
      else if (out_valid && out_ready)
         count_nxt = '0;
   end

   // Beat ordinal register
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= count_nxt;
   end

   assign out_count = count;
`else
   logic unused_load;
   assign unused_load = load;
`endif

endmodule
